archel_run_ctrl: RTL and testbench

- Parametrised run/pause/step controller sitting between the board buttons (PAUSE, STEP) and the archel core.
- Generates the core clock-enable CPU_EN and stops the core only at instruction boundaries.
- Extends single-button stepping with:
  - debounce;
  - N-instruction step bursts;
  - auto-repeat while STEP is held;
  - N_BP hardware PC breakpoints.

---
 rtl/archel_dbg_pkg.sv | 14 +
 rtl/archel_btn_debounce.sv | 78 +++++++
 rtl/archel_run_ctrl.sv | 141 ++++++++++++++
 tb/tb_archel_run_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/archel_dbg_pkg.sv
// Shared types and defaults for the archel debug/run-control blocks.
package archel_dbg_pkg;

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StHalt     = 2'd1,
        StStepping = 2'd2
    } run_state_e;

    localparam int unsigned BP_IDX_W            = 3;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_REPEAT_CYCLES   = 16;

endpackage

// File: rtl/archel_btn_debounce.sv
// Button conditioner: 2-FF sync, debounce counter, one-cycle press pulse and
// auto-repeat pulses while the debounced level stays high.
module archel_btn_debounce
    import archel_dbg_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned DB_MAX = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
    localparam int unsigned DB_W   = (DB_MAX > 0) ? $clog2(DB_MAX + 1) : 1;
    localparam int unsigned RP_MAX = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;
    localparam int unsigned RP_W   = (RP_MAX > 0) ? $clog2(RP_MAX + 1) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_MAX);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(RP_MAX);
    localparam logic REPEAT_ON = (REPEAT_CYCLES != 0);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            prev_q;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic [RP_W-1:0] rep_q, rep_d;
    logic            pulse_q, pulse_d;
    logic            rise, rep_hit;

    // The level only flips after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + DB_W'(1);
        end
    end

    always_comb begin
        rise    = level_q & ~prev_q;
        rep_hit = REPEAT_ON & level_q & prev_q & (rep_q == RP_LAST);
        pulse_d = rise | rep_hit;
        if (!level_q || rise || rep_hit) begin
            rep_d = '0;
        end else begin
            rep_d = rep_q + RP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            rep_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/archel_run_ctrl.sv
// Run/pause/step controller for the archel core: gates CPU_EN at instruction
// boundaries, supports step bursts, auto-repeat stepping and PC breakpoints.
module archel_run_ctrl
    import archel_dbg_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int unsigned STEP_W          = 8,
    parameter int unsigned PC_W            = 16,
    parameter int unsigned N_BP            = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pause,
    input  logic                   step,
    input  logic [STEP_W-1:0]      step_count,
    input  logic                   instr_done,
    input  logic [PC_W-1:0]        pc_next,
    input  logic [N_BP*PC_W-1:0]   bp_addr,
    input  logic [N_BP-1:0]        bp_en,
    output logic                   cpu_en,
    output logic                   halted,
    output logic                   bp_hit,
    output logic [BP_IDX_W-1:0]    bp_idx,
    output logic [STEP_W-1:0]      steps_left,
    output logic [1:0]             state
);

    logic pause_s1_q, pause_s2_q;
    logic stp_req;

    archel_btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_step_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (step),
        .pulse (stp_req)
    );

    run_state_e          state_q, state_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic                bp_hit_q, bp_hit_d;
    logic [BP_IDX_W-1:0] bp_idx_q, bp_idx_d;
    logic                cpu_en_q, halted_q;
    logic                done;
    logic                bp_any;
    logic [BP_IDX_W-1:0] bp_sel;
    logic [STEP_W-1:0]   burst_len;
    logic [STEP_W-1:0]   steps_dec;

    // INSTR_DONE is only meaningful while the core is actually enabled.
    assign done      = instr_done & cpu_en_q;
    assign burst_len = (step_count == '0) ? STEP_W'(1) : step_count;
    assign steps_dec = (steps_q == '0) ? '0 : steps_q - STEP_W'(1);

    // Scan downwards so the lowest matching slot is the one reported.
    always_comb begin
        bp_any = 1'b0;
        bp_sel = '0;
        for (int i = int'(N_BP) - 1; i >= 0; i--) begin
            if (bp_en[i] && (bp_addr[i*PC_W +: PC_W] == pc_next)) begin
                bp_any = 1'b1;
                bp_sel = BP_IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        steps_d  = steps_q;
        bp_hit_d = bp_hit_q;
        bp_idx_d = bp_idx_q;
        case (state_q)
            StRun: begin
                if (done) begin
                    if (bp_any) begin
                        state_d  = StHalt;
                        bp_hit_d = 1'b1;
                        bp_idx_d = bp_sel;
                    end else if (pause_s2_q) begin
                        state_d = StHalt;
                    end
                end
            end
            StHalt: begin
                if (stp_req) begin
                    steps_d  = burst_len;
                    bp_hit_d = 1'b0;
                    state_d  = pause_s2_q ? StStepping : StRun;
                end else if (!pause_s2_q && !bp_hit_q) begin
                    state_d = StRun;
                end
            end
            StStepping: begin
                if (done) begin
                    steps_d = steps_dec;
                    if (bp_any) begin
                        state_d  = StHalt;
                        bp_hit_d = 1'b1;
                        bp_idx_d = bp_sel;
                    end else if (steps_dec == '0) begin
                        state_d = StHalt;
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_s1_q <= 1'b0;
            pause_s2_q <= 1'b0;
            state_q    <= StRun;
            steps_q    <= '0;
            bp_hit_q   <= 1'b0;
            bp_idx_q   <= '0;
            cpu_en_q   <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pause_s1_q <= pause;
            pause_s2_q <= pause_s1_q;
            state_q    <= state_d;
            steps_q    <= steps_d;
            bp_hit_q   <= bp_hit_d;
            bp_idx_q   <= bp_idx_d;
            cpu_en_q   <= (state_d != StHalt);
            halted_q   <= (state_d == StHalt);
        end
    end

    assign cpu_en     = cpu_en_q;
    assign halted     = halted_q;
    assign bp_hit     = bp_hit_q;
    assign bp_idx     = bp_idx_q;
    assign steps_left = steps_q;
    assign state      = state_q;

endmodule

// File: tb/tb_archel_run_ctrl.sv
// Self-checking bench for archel_run_ctrl: breakpoint vector table plus a
// step-burst scoreboard driven by a simple 3-cycle-per-instruction core model.
`timescale 1ns/1ps
module tb_archel_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pause;
    logic        step;
    logic [7:0]  step_count;
    logic        instr_done;
    logic [15:0] pc_next;
    logic [31:0] bp_addr;
    logic [1:0]  bp_en;
    logic        cpu_en;
    logic        halted;
    logic        bp_hit;
    logic [2:0]  bp_idx;
    logic [7:0]  steps_left;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    archel_run_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (16),
        .STEP_W          (8),
        .PC_W            (16),
        .N_BP            (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pause      (pause),
        .step       (step),
        .step_count (step_count),
        .instr_done (instr_done),
        .pc_next    (pc_next),
        .bp_addr    (bp_addr),
        .bp_en      (bp_en),
        .cpu_en     (cpu_en),
        .halted     (halted),
        .bp_hit     (bp_hit),
        .bp_idx     (bp_idx),
        .steps_left (steps_left),
        .state      (state)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Core model: one instruction every 3 enabled cycles; progress freezes while disabled.
    int phase = 0;
    initial begin
        instr_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cpu_en === 1'b1) begin
                if (phase == 2) begin
                    instr_done = 1'b1;
                    phase      = 0;
                end else begin
                    instr_done = 1'b0;
                    phase++;
                end
            end else begin
                instr_done = 1'b0;
            end
        end
    end

    typedef struct {
        int n;
        int bp;
        int start;
    } burst_t;

    burst_t     sb[$];
    burst_t     cur;
    bit         in_burst   = 1'b0;
    int         burst_n    = 0;
    int         retired    = 0;
    logic [1:0] prev_state = 2'd0;

    task automatic push_burst(input int n, input int bp, input int start);
        burst_t b;
        b.n     = n;
        b.bp    = bp;
        b.start = start;
        sb.push_back(b);
    endtask

    // Burst scoreboard: pop on entry to STEPPING, compare on return to HALT.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            in_burst   = 1'b0;
            prev_state = 2'd0;
        end else begin
            if (instr_done === 1'b1 && cpu_en === 1'b1) retired++;
            if (state == 2'd2 && prev_state != 2'd2) begin
                if (sb.size() == 0) begin
                    check("burst_unexpected", 1, 0);
                end else begin
                    cur      = sb.pop_front();
                    in_burst = 1'b1;
                    burst_n  = 0;
                    check("burst_load", int'(steps_left), cur.start);
                end
            end
            if (in_burst && state == 2'd2 && instr_done === 1'b1 && cpu_en === 1'b1) begin
                check("steps_left_dec", int'(steps_left), cur.start - burst_n);
                burst_n++;
            end
            if (in_burst && state == 2'd1 && prev_state == 2'd2) begin
                check("burst_len", burst_n, cur.n);
                check("burst_bp", int'(bp_hit), cur.bp);
                check("burst_steps_end", int'(steps_left), cur.start - cur.n);
                in_burst = 1'b0;
            end
            prev_state = state;
        end
    end

    task automatic wait_state(input logic [1:0] s, input int max, input string name);
        int k;
        k = 0;
        while (state !== s && k < max) begin
            @(negedge clk);
            k++;
        end
        check(name, int'(state), int'(s));
    endtask

    task automatic wait_done(input int max, input string name);
        int k;
        k = 0;
        while (!(instr_done === 1'b1 && cpu_en === 1'b1) && k < max) begin
            @(negedge clk);
            k++;
        end
        check(name, int'(k < max), 1);
    endtask

    task automatic wait_bursts(input int max, input string name);
        int k;
        k = 0;
        while ((sb.size() != 0 || in_burst || state !== 2'd1) && k < max) begin
            @(negedge clk);
            k++;
        end
        check({name, "_pending"}, sb.size() + int'(in_burst), 0);
        check({name, "_halt"}, int'(state), 1);
    endtask

    task automatic press(input int hold);
        @(posedge clk);
        #2;
        step = 1'b1;
        repeat (hold) @(posedge clk);
        #2;
        step = 1'b0;
        repeat (10) @(posedge clk);
        #2;
    endtask

    typedef struct {
        logic [1:0]  en;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [15:0] pc;
        int          hit;
        int          idx;
    } bpvec_t;

    bpvec_t tbl[7];

    initial begin
        int hcount;
        int r0;

        tbl[0] = '{en: 2'b10, a0: 16'h0000, a1: 16'h0040, pc: 16'h0040, hit: 1, idx: 1};
        tbl[1] = '{en: 2'b11, a0: 16'h0040, a1: 16'h0040, pc: 16'h0040, hit: 1, idx: 0};
        tbl[2] = '{en: 2'b01, a0: 16'h0040, a1: 16'h0040, pc: 16'h0040, hit: 1, idx: 0};
        tbl[3] = '{en: 2'b00, a0: 16'h0040, a1: 16'h0040, pc: 16'h0040, hit: 0, idx: 0};
        tbl[4] = '{en: 2'b11, a0: 16'h1234, a1: 16'h5678, pc: 16'h5678, hit: 1, idx: 1};
        tbl[5] = '{en: 2'b11, a0: 16'h1234, a1: 16'h5678, pc: 16'h1235, hit: 0, idx: 0};
        tbl[6] = '{en: 2'b10, a0: 16'hbeef, a1: 16'h0040, pc: 16'hbeef, hit: 0, idx: 0};

        rst_n      = 1'b0;
        pause      = 1'b0;
        step       = 1'b0;
        step_count = 8'd0;
        pc_next    = 16'h1000;
        bp_addr    = '0;
        bp_en      = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #2;
        check("rst_cpu_en", int'(cpu_en), 0);
        check("rst_halted", int'(halted), 0);
        check("rst_bp_hit", int'(bp_hit), 0);
        check("rst_bp_idx", int'(bp_idx), 0);
        check("rst_steps_left", int'(steps_left), 0);
        check("rst_state", int'(state), 0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("first_edge_cpu_en", int'(cpu_en), 1);
        check("first_edge_state", int'(state), 0);

        hcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (halted !== 1'b0) hcount++;
        end
        check("run_no_halt", hcount, 0);
        check("run_retires", int'(retired >= 5), 1);

        // PAUSE mid-instruction: exactly one more instruction commits
        wait_done(20, "pause_done_seen");
        @(posedge clk);
        #2;
        pause = 1'b1;
        r0    = retired;
        wait_state(2'd1, 20, "pause_halt_state");
        check("pause_one_more_instr", retired - r0, 1);
        check("pause_cpu_en", int'(cpu_en), 0);
        check("pause_halted", int'(halted), 1);

        // Glitchy STEP then held 8 cycles: one request, 3-instruction burst
        step_count = 8'd3;
        push_burst(3, 0, 3);
        @(posedge clk);
        #2;
        for (int i = 0; i < 6; i++) begin
            step = (i % 2 == 0);
            @(posedge clk);
            #2;
        end
        step = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        step = 1'b0;
        wait_bursts(100, "glitch_burst");

        // STEP held 60 cycles, count 0: press + 3 repeats, one instruction each
        repeat (10) @(posedge clk);
        #2;
        step_count = 8'd0;
        for (int i = 0; i < 4; i++) push_burst(1, 0, 1);
        step = 1'b1;
        repeat (60) @(posedge clk);
        #2;
        step = 1'b0;
        wait_bursts(100, "repeat_bursts");
        repeat (30) @(posedge clk);
        #2;

        // Long burst: repeat requests arriving mid-burst are dropped
        step_count = 8'd20;
        push_burst(20, 0, 20);
        step = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        step = 1'b0;
        wait_bursts(200, "drop_burst");
        repeat (40) @(posedge clk);
        #2;
        check("drop_queue_empty", sb.size(), 0);

        // Breakpoint hit during a burst wins over the remaining count
        bp_en      = 2'b01;
        bp_addr    = {16'h0000, 16'h1000};
        step_count = 8'd5;
        push_burst(1, 1, 5);
        press(8);
        wait_bursts(100, "step_bp_burst");
        check("step_bp_idx", int'(bp_idx), 0);
        bp_en      = 2'b00;
        step_count = 8'd1;
        push_burst(1, 0, 1);
        press(8);
        wait_bursts(100, "step_clear_burst");
        check("step_clear_bp_hit", int'(bp_hit), 0);

        pause = 1'b0;
        wait_state(2'd0, 20, "pause_release_run");

        // Breakpoint vector table in RUN
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #2;
            bp_en   = tbl[i].en;
            bp_addr = {tbl[i].a1, tbl[i].a0};
            pc_next = tbl[i].pc;
            wait_done(20, "bp_done_seen");
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp%0d_state", i), int'(state), tbl[i].hit);
            check($sformatf("bp%0d_hit", i), int'(bp_hit), tbl[i].hit);
            check($sformatf("bp%0d_cpu_en", i), int'(cpu_en), 1 - tbl[i].hit);
            if (tbl[i].hit != 0) begin
                check($sformatf("bp%0d_idx", i), int'(bp_idx), tbl[i].idx);
                pc_next = 16'h2000;
                press(8);
                check($sformatf("bp%0d_resume_state", i), int'(state), 0);
                check($sformatf("bp%0d_resume_hit", i), int'(bp_hit), 0);
                for (int j = 0; j < 2; j++) begin
                    wait_done(20, "bp_resume_done_seen");
                    @(posedge clk);
                    @(negedge clk);
                end
                check($sformatf("bp%0d_no_rehit", i), int'(state), 0);
            end
        end

        // Reset asserted mid-burst aborts it immediately
        bp_en = 2'b00;
        pause = 1'b1;
        wait_state(2'd1, 20, "pre_reset_halt");
        step_count = 8'd5;
        push_burst(5, 0, 5);
        @(posedge clk);
        #2;
        step = 1'b1;
        wait_state(2'd2, 30, "pre_reset_stepping");
        check("pre_reset_steps", int'(steps_left), 5);
        #1;
        step  = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midburst_rst_state", int'(state), 0);
        check("midburst_rst_cpu_en", int'(cpu_en), 0);
        check("midburst_rst_steps", int'(steps_left), 0);
        check("midburst_rst_bp_hit", int'(bp_hit), 0);
        check("midburst_rst_halted", int'(halted), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check("final_queue_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d bad", n_cmp,
                 n_bad);
        $fatal(1, "watchdog");
    end

endmodule
